matrix_result_collector: RTL and testbench

- Sink for the matrix multiply engine's result stream. It captures each `data_o_v`/`data_o` strobe into a local result buffer in generation order: the ROW1 index is the inner loop and the COL index is the outer loop.
- It tracks completion against `cal_finish_o` and flags count mismatches.
- It then replays the full result matrix to the next Kalman stage over a valid/ready stream.

---
 rtl/matrix_result_collector_pkg.sv | 26 ++
 rtl/matrix_result_collector_if.sv | 38 +++
 rtl/matrix_result_collector_buf.sv | 27 ++
 rtl/matrix_result_collector.sv | 164 ++++++++++++++++
 tb/tb_matrix_result_collector.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_result_collector_pkg.sv
// Shared types and constants for the matrix result collector.
package matrix_result_collector_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2,
    STREAM  = 2'd3
  } state_t;

  // Buffer layout selectors.
  localparam int LAYOUT_COL_MAJOR = 0;
  localparam int LAYOUT_ROW_MAJOR = 1;

  // Address width of a buffer holding `depth` words (at least one bit).
  function automatic int buf_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Default geometry and the matching buffer address width.
  localparam int DEF_MAX_COL  = 4;
  localparam int DEF_MAX_ROW1 = 4;
  localparam int DEF_ADDR_W   = buf_addr_w(DEF_MAX_COL * DEF_MAX_ROW1);

endpackage

// File: rtl/matrix_result_collector_if.sv
// Job control, result strobe and replay stream of the matrix result collector.
interface matrix_result_collector_if #(
  parameter int MAX_COL  = 4,
  parameter int MAX_ROW1 = 4,
  parameter int DATA_W   = 16
);
  localparam int COL_W = $clog2(MAX_COL) + 1;
  localparam int ROW_W = $clog2(MAX_ROW1) + 1;

  logic              start_i;
  logic [COL_W-1:0]  col_i;
  logic [ROW_W-1:0]  row1_i;
  logic              data_i_v;
  logic [DATA_W-1:0] data_i;
  logic              cal_finish_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic              rd_start_i;
  logic              rd_valid_o;
  logic              rd_ready_i;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_last_o;

  // Environment side: engine, job controller and downstream consumer.
  modport master (
    output start_i, col_i, row1_i, data_i_v, data_i, cal_finish_i,
    output rd_start_i, rd_ready_i,
    input  busy_o, done_o, err_o, rd_valid_o, rd_data_o, rd_last_o
  );

  // Collector side.
  modport slave (
    input  start_i, col_i, row1_i, data_i_v, data_i, cal_finish_i,
    input  rd_start_i, rd_ready_i,
    output busy_o, done_o, err_o, rd_valid_o, rd_data_o, rd_last_o
  );
endinterface

// File: rtl/matrix_result_collector_buf.sv
// Simple dual-port result buffer: one write port, one registered read port
// with read enable so the read register can be held during back-pressure.
module result_buf_sdp #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; holds its word while rd_en is low.
  always_ff @(posedge clk_i) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/matrix_result_collector.sv
// Collects the matrix engine result stream into a local buffer, checks the
// word count against the job-complete pulse, and replays the buffer on a
// valid/ready stream with a registered output stage.
module matrix_result_collector
  import matrix_result_collector_pkg::*;
#(
  parameter int MAX_COL   = DEF_MAX_COL,
  parameter int MAX_ROW1  = DEF_MAX_ROW1,
  parameter int DATA_W    = 16,
  parameter int ROW_MAJOR = LAYOUT_COL_MAJOR
) (
  input logic                    clk_i,
  input logic                    rst_i,
  matrix_result_collector_if.slave bus
);
  localparam int COL_W  = $clog2(MAX_COL) + 1;
  localparam int ROW_W  = $clog2(MAX_ROW1) + 1;
  localparam int CNT_W  = COL_W + ROW_W;
  localparam int DEPTH  = MAX_COL * MAX_ROW1;
  localparam int ADDR_W = buf_addr_w(DEPTH);

  state_t            state;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row1_q;
  logic [CNT_W-1:0]  n_q;
  logic [CNT_W-1:0]  wr_cnt;
  logic [ROW_W-1:0]  b_q;
  logic [COL_W-1:0]  c_q;
  logic [CNT_W-1:0]  rd_cnt;

  logic              vld_p1;
  logic              last_p1;
  logic [DATA_W-1:0] data_p1;

  logic              dims_ok;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  wr_cnt_nxt;
  logic              adv;
  logic              issue;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;

  // Job validation, write addressing and read-pipeline control.
  always_comb begin
    dims_ok = (bus.col_i != '0) && (bus.col_i <= COL_W'(MAX_COL)) &&
              (bus.row1_i != '0) && (bus.row1_i <= ROW_W'(MAX_ROW1));
    wr_en      = (state == COLLECT) && bus.data_i_v && (wr_cnt < n_q);
    wr_cnt_nxt = wr_en ? (wr_cnt + CNT_W'(1)) : wr_cnt;
    if (ROW_MAJOR == LAYOUT_ROW_MAJOR)
      wr_addr = ADDR_W'(CNT_W'(b_q) * CNT_W'(col_q) + CNT_W'(c_q));
    else
      wr_addr = ADDR_W'(CNT_W'(c_q) * CNT_W'(row1_q) + CNT_W'(b_q));
    // The whole read pipeline moves together whenever the output stage
    // is empty or being consumed.
    adv     = !bus.rd_valid_o || bus.rd_ready_i;
    issue   = (state == STREAM) && (rd_cnt < n_q);
    rd_en   = adv && issue;
    rd_addr = ADDR_W'(rd_cnt);
  end

  result_buf_sdp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk_i   (clk_i),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (bus.data_i),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (data_p1)
  );

  // Controller FSM, counters and the registered output stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      col_q          <= '0;
      row1_q         <= '0;
      n_q            <= '0;
      wr_cnt         <= '0;
      b_q            <= '0;
      c_q            <= '0;
      rd_cnt         <= '0;
      vld_p1         <= 1'b0;
      last_p1        <= 1'b0;
      bus.busy_o     <= 1'b0;
      bus.done_o     <= 1'b0;
      bus.err_o      <= 1'b0;
      bus.rd_valid_o <= 1'b0;
      bus.rd_last_o  <= 1'b0;
      bus.rd_data_o  <= '0;
    end else begin
      bus.done_o <= 1'b0;
      case (state)
        IDLE, FULL: begin
          if (bus.start_i) begin
            if (!dims_ok) begin
              bus.err_o <= 1'b1;
            end else begin
              col_q      <= bus.col_i;
              row1_q     <= bus.row1_i;
              n_q        <= CNT_W'(bus.col_i) * CNT_W'(bus.row1_i);
              wr_cnt     <= '0;
              b_q        <= '0;
              c_q        <= '0;
              bus.err_o  <= 1'b0;
              bus.busy_o <= 1'b1;
              state      <= COLLECT;
            end
          end else if ((state == FULL) && bus.rd_start_i) begin
            rd_cnt     <= '0;
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            bus.busy_o <= 1'b1;
            state      <= STREAM;
          end
        end
        COLLECT: begin
          if (wr_en) begin
            wr_cnt <= wr_cnt_nxt;
            if (b_q == row1_q - ROW_W'(1)) begin
              b_q <= '0;
              c_q <= c_q + COL_W'(1);
            end else begin
              b_q <= b_q + ROW_W'(1);
            end
          end
          // Overflow: the word is dropped.
          if (bus.data_i_v && !wr_en) bus.err_o <= 1'b1;
          // Completion check sees any write from this same cycle.
          if (bus.cal_finish_i) begin
            state      <= FULL;
            bus.busy_o <= 1'b0;
            if (wr_cnt_nxt == n_q) bus.done_o <= 1'b1;
            else                   bus.err_o  <= 1'b1;
          end
        end
        STREAM: begin
          // p1 = buffer read register, p2 = output stage.
          if (adv) begin
            bus.rd_valid_o <= vld_p1;
            bus.rd_last_o  <= last_p1;
            if (vld_p1) bus.rd_data_o <= data_p1;
            vld_p1  <= issue;
            last_p1 <= issue && (rd_cnt == n_q - CNT_W'(1));
            if (issue) rd_cnt <= rd_cnt + CNT_W'(1);
          end
          if (bus.rd_valid_o && bus.rd_ready_i && bus.rd_last_o) begin
            bus.rd_valid_o <= 1'b0;
            bus.rd_last_o  <= 1'b0;
            vld_p1         <= 1'b0;
            last_p1        <= 1'b0;
            bus.busy_o     <= 1'b0;
            state          <= FULL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_result_collector.sv
// Directed bench for matrix_result_collector: one column-major and one
// row-major instance driven with identical stimulus.
module tb_matrix_result_collector;
  localparam int MAX_COL  = 4;
  localparam int MAX_ROW1 = 4;
  localparam int DATA_W   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start;
  logic [2:0]        col;
  logic [2:0]        row1;
  logic              dv;
  logic [DATA_W-1:0] din;
  logic              cf;
  logic              rs;
  logic              rdy;

  matrix_result_collector_if #(.MAX_COL(MAX_COL), .MAX_ROW1(MAX_ROW1), .DATA_W(DATA_W)) bus0 ();
  matrix_result_collector_if #(.MAX_COL(MAX_COL), .MAX_ROW1(MAX_ROW1), .DATA_W(DATA_W)) bus1 ();

  assign bus0.start_i = start;  assign bus1.start_i = start;
  assign bus0.col_i = col;      assign bus1.col_i = col;
  assign bus0.row1_i = row1;    assign bus1.row1_i = row1;
  assign bus0.data_i_v = dv;    assign bus1.data_i_v = dv;
  assign bus0.data_i = din;     assign bus1.data_i = din;
  assign bus0.cal_finish_i = cf; assign bus1.cal_finish_i = cf;
  assign bus0.rd_start_i = rs;  assign bus1.rd_start_i = rs;
  assign bus0.rd_ready_i = rdy; assign bus1.rd_ready_i = rdy;

  matrix_result_collector #(
    .MAX_COL(MAX_COL), .MAX_ROW1(MAX_ROW1), .DATA_W(DATA_W), .ROW_MAJOR(0)
  ) u_cm (.clk_i(clk), .rst_i(rst), .bus(bus0));

  matrix_result_collector #(
    .MAX_COL(MAX_COL), .MAX_ROW1(MAX_ROW1), .DATA_W(DATA_W), .ROW_MAJOR(1)
  ) u_rm (.clk_i(clk), .rst_i(rst), .bus(bus1));

  typedef struct {
    int          col;
    int          row1;
    int          nwords;
    bit          coinc;
    logic [15:0] base;
    int          exp_done;
    int          exp_err;
    bit          replay;
  } job_t;

  job_t jobs [4];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Word expected at replay position idx: generation index g is the
  // b-inner / c-outer order, data = base + g.
  function automatic logic [31:0] exp_word(input job_t j, input int idx, input bit row_major);
    int b, c, g;
    if (row_major) begin
      b = idx / j.col;
      c = idx % j.col;
      g = c * j.row1 + b;
    end else begin
      g = idx;
    end
    return 32'(j.base) + 32'(g);
  endfunction

  task automatic run_job(input job_t j, output int done_cnt);
    done_cnt = 0;
    start = 1'b1; col = 3'(j.col); row1 = 3'(j.row1);
    tick();
    start = 1'b0;
    chk("busy_collect", 32'(bus0.busy_o), 32'd1);
    for (int k = 0; k < j.nwords; k++) begin
      dv  = 1'b1;
      din = j.base + 16'(k);
      cf  = j.coinc && (k == j.nwords - 1);
      tick();
      done_cnt += int'(bus0.done_o);
    end
    dv = 1'b0;
    if (!j.coinc) begin
      cf = 1'b1;
      tick();
      done_cnt += int'(bus0.done_o);
    end
    cf = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      done_cnt += int'(bus0.done_o);
    end
  endtask

  task automatic replay(input job_t j, input bit stall);
    bit   pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int   n = j.col * j.row1;
    int   hs = 0;
    int   cyc = 0;
    bit   prev_stalled = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    rdy = 1'b0;
    rs  = 1'b1;
    tick();
    rs = 1'b0;
    chk("lat_e0_valid", 32'(bus0.rd_valid_o), 32'd0);
    tick();
    chk("lat_e1_valid", 32'(bus0.rd_valid_o), 32'd0);
    tick();
    chk("first_valid", 32'(bus0.rd_valid_o), 32'd1);
    while (hs < n && cyc < 40) begin
      rdy = stall ? ((cyc < 7) ? pat[cyc] : 1'b1) : 1'b1;
      if (prev_stalled) chk("stall_hold", 32'(bus0.rd_data_o), 32'(prev_data));
      if (!stall) chk("stream_valid", 32'(bus0.rd_valid_o), 32'd1);
      if (bus0.rd_valid_o && rdy) begin
        chk("data_colmajor", 32'(bus0.rd_data_o), exp_word(j, hs, 1'b0));
        chk("data_rowmajor", 32'(bus1.rd_data_o), exp_word(j, hs, 1'b1));
        chk("last_flag", 32'(bus0.rd_last_o), (hs == n - 1) ? 32'd1 : 32'd0);
        hs++;
      end
      prev_stalled = bus0.rd_valid_o && !rdy;
      prev_data    = bus0.rd_data_o;
      tick();
      cyc++;
    end
    chk("replay_handshakes", 32'(hs), 32'(n));
    rdy = 1'b1;
    chk("end_valid", 32'(bus0.rd_valid_o), 32'd0);
    chk("end_busy", 32'(bus0.busy_o), 32'd0);
    tick();
    chk("end_valid_after", 32'(bus0.rd_valid_o), 32'd0);
    rdy = 1'b0;
  endtask

  initial begin
    int done_cnt;
    rst = 1'b1; start = 1'b0; col = '0; row1 = '0; dv = 1'b0; din = '0;
    cf = 1'b0; rs = 1'b0; rdy = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(bus0.busy_o), 32'd0);
    chk("rst_done", 32'(bus0.done_o), 32'd0);
    chk("rst_err", 32'(bus0.err_o), 32'd0);
    chk("rst_valid", 32'(bus0.rd_valid_o), 32'd0);
    chk("rst_last", 32'(bus0.rd_last_o), 32'd0);
    chk("rst_data", 32'(bus0.rd_data_o), 32'd0);
    chk("rst_valid_rm", 32'(bus1.rd_valid_o), 32'd0);
    rst = 1'b0;
    tick();

    jobs[0] = '{2, 3, 6, 1'b0, 16'h0011, 1, 0, 1'b1};
    jobs[1] = '{2, 2, 3, 1'b0, 16'h0021, 0, 1, 1'b0};
    jobs[2] = '{2, 2, 5, 1'b0, 16'h0031, 1, 1, 1'b1};
    jobs[3] = '{2, 2, 4, 1'b1, 16'h0041, 1, 0, 1'b0};

    for (int i = 0; i < 4; i++) begin
      run_job(jobs[i], done_cnt);
      chk("job_done_pulses", 32'(done_cnt), 32'(jobs[i].exp_done));
      chk("job_err", 32'(bus0.err_o), 32'(jobs[i].exp_err));
      chk("job_err_rm", 32'(bus1.err_o), 32'(jobs[i].exp_err));
      chk("job_busy_full", 32'(bus0.busy_o), 32'd0);
      if (jobs[i].replay) replay(jobs[i], 1'b0);
    end

    // Back-pressured replay of the last job, then a second replay of the
    // retained buffer.
    replay(jobs[3], 1'b1);
    replay(jobs[3], 1'b0);

    // Reset in the middle of collection.
    start = 1'b1; col = 3'd2; row1 = 3'd2;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      dv = 1'b1; din = 16'h0051 + 16'(k);
      tick();
    end
    dv = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 32'(bus0.busy_o), 32'd0);
    chk("midrst_err", 32'(bus0.err_o), 32'd0);
    chk("midrst_done", 32'(bus0.done_o), 32'd0);
    cf = 1'b1;
    tick();
    cf = 1'b0;
    chk("idle_cf_done", 32'(bus0.done_o), 32'd0);
    tick();
    chk("idle_cf_done2", 32'(bus0.done_o), 32'd0);

    // Bad dimensions keep the collector in IDLE with err_o set.
    start = 1'b1; col = 3'd0; row1 = 3'd2;
    tick();
    start = 1'b0;
    chk("zero_col_err", 32'(bus0.err_o), 32'd1);
    chk("zero_col_busy", 32'(bus0.busy_o), 32'd0);
    rs = 1'b1;
    tick();
    rs = 1'b0;
    tick();
    tick();
    chk("idle_no_stream", 32'(bus0.rd_valid_o), 32'd0);
    chk("idle_no_stream_busy", 32'(bus0.busy_o), 32'd0);
    start = 1'b1; col = 3'd2; row1 = 3'd5;
    tick();
    start = 1'b0;
    chk("big_row1_err", 32'(bus0.err_o), 32'd1);
    chk("big_row1_busy", 32'(bus0.busy_o), 32'd0);
    start = 1'b1; col = 3'd1; row1 = 3'd1;
    tick();
    start = 1'b0;
    chk("good_start_err_clr", 32'(bus0.err_o), 32'd0);
    chk("good_start_busy", 32'(bus0.busy_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
